// File: rtl/wb_accum_pkg.sv
// Shared types and defaults for the weight/bias accumulate datapath.
// Imported by the MAC sub-module and the top-level FSM.
package wb_accum_pkg;

    localparam int DEF_DW       = 6;
    localparam int DEF_AW       = 16;
    localparam int TGT_ZERO_MAP = 1 << DEF_DW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/wb_sat_mac.sv
// Combinational unsigned multiply with saturating accumulate.
// The sum is formed one bit wider than the accumulator to detect overflow.
module wb_sat_mac
    import wb_accum_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic [AW-1:0] acc,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] next_acc,
    output logic          clamp
);

    logic [2*DW-1:0] prod;
    logic [AW:0]     sum;

    always_comb begin
        prod     = w * b;
        sum      = {1'b0, acc} + (AW+1)'(prod);
        clamp    = sum[AW];
        next_acc = clamp ? '1 : sum[AW-1:0];
    end

endmodule

// File: rtl/wb_accum_datapath.sv
// Weight/bias accumulate engine: load a weight and sample target, then
// accumulate w*b per cnt strobe with saturation and pulse valid when done.
module wb_accum_datapath
    import wb_accum_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] w_in,
    input  logic          load_w_in,
    input  logic [DW-1:0] s_in,
    input  logic          cnt_in,
    input  logic [DW-1:0] b_in,
    output logic [AW-1:0] acc_out,
    output logic          valid_out,
    output logic          busy_out,
    output logic          sat_out,
    output logic          err_out,
    output logic [1:0]    ps_out
);

    localparam int CW = DW + 1;

    state_t        state;
    logic [DW-1:0] w_reg;
    logic [CW-1:0] tgt;
    logic [CW-1:0] count;
    logic [AW-1:0] acc;
    logic          sat;
    logic          err;

    logic [AW-1:0] mac_acc;
    logic          mac_clamp;
    logic [CW-1:0] tgt_in;
    logic [CW-1:0] count_nx;
    logic          last;

    wb_sat_mac #(
        .DW(DW),
        .AW(AW)
    ) u_mac (
        .acc     (acc),
        .w       (w_reg),
        .b       (b_in),
        .next_acc(mac_acc),
        .clamp   (mac_clamp)
    );

    // A zero target means the full 2^DW samples; count is one bit wider.
    always_comb begin
        tgt_in   = (s_in == '0) ? (CW'(1) << DW) : {1'b0, s_in};
        count_nx = (state == LOADED) ? CW'(1) : count + CW'(1);
        last     = (count_nx == tgt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            w_reg <= '0;
            tgt   <= '0;
            count <= '0;
            acc   <= '0;
            sat   <= 1'b0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (load_w_in) begin
                        w_reg <= w_in;
                        tgt   <= tgt_in;
                        acc   <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                        err   <= 1'b0;
                        state <= LOADED;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOADED: begin
                    if (load_w_in) begin
                        w_reg <= w_in;
                        tgt   <= tgt_in;
                        acc   <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                    end else if (cnt_in) begin
                        acc   <= mac_acc;
                        sat   <= sat | mac_clamp;
                        count <= count_nx;
                        state <= last ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    // A load mid-job is a protocol error and is dropped.
                    if (load_w_in) begin
                        err <= 1'b1;
                    end
                    if (cnt_in) begin
                        acc   <= mac_acc;
                        sat   <= sat | mac_clamp;
                        count <= count_nx;
                        if (last) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        acc_out   = acc;
        valid_out = (state == DONE);
        busy_out  = (state == LOADED) || (state == ACCUM);
        sat_out   = sat;
        err_out   = err;
        ps_out    = state;
    end

endmodule

// File: tb/tb_wb_accum_datapath.sv
// Directed bench for wb_accum_datapath with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_wb_accum_datapath;

    logic        clk;
    logic        reset;
    logic [5:0]  w_in;
    logic        load_w_in;
    logic [5:0]  s_in;
    logic        cnt_in;
    logic [5:0]  b_in;
    logic [15:0] acc_out;
    logic        valid_out;
    logic        busy_out;
    logic        sat_out;
    logic        err_out;
    logic [1:0]  ps_out;

    int n_tests;
    int n_fail;

    wb_accum_datapath #(
        .DW(6),
        .AW(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .w_in     (w_in),
        .load_w_in(load_w_in),
        .s_in     (s_in),
        .cnt_in   (cnt_in),
        .b_in     (b_in),
        .acc_out  (acc_out),
        .valid_out(valid_out),
        .busy_out (busy_out),
        .sat_out  (sat_out),
        .err_out  (err_out),
        .ps_out   (ps_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic l, input logic [5:0] w, input logic [5:0] s,
                        input logic c, input logic [5:0] b);
        load_w_in = l;
        w_in      = w;
        s_in      = s;
        cnt_in    = c;
        b_in      = b;
        @(posedge clk);
        #1;
        load_w_in = 1'b0;
        cnt_in    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        n_tests++;
        if ({acc_out, valid_out, busy_out, sat_out, err_out, ps_out} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got acc=%0d v=%b b=%b s=%b e=%b ps=%0d, want all 0",
                     acc_out, valid_out, busy_out, sat_out, err_out, ps_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, 6'd0, 6'd0, 1'b1, 6'd7);
        n_tests++;
        if (ps_out !== 2'd0 || acc_out !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_ignores_cnt: got ps=%0d acc=%0d, want ps=0 acc=0", ps_out, acc_out);
        end
    endtask

    task automatic test_basic;
        logic [15:0] exp_acc [3] = '{16'd10, 16'd30, 16'd60};
        logic [5:0]  bs      [3] = '{6'd2, 6'd4, 6'd6};
        step(1'b1, 6'd5, 6'd3, 1'b0, 6'd0);
        n_tests++;
        if (ps_out !== 2'd1 || busy_out !== 1'b1 || acc_out !== 16'd0) begin
            n_fail++;
            $display("FAIL basic_load: got ps=%0d busy=%b acc=%0d, want ps=1 busy=1 acc=0",
                     ps_out, busy_out, acc_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'd0, 6'd0, 1'b1, bs[i]);
            n_tests++;
            if (acc_out !== exp_acc[i] || valid_out !== (i == 2)) begin
                n_fail++;
                $display("FAIL basic_acc%0d: got acc=%0d valid=%b, want acc=%0d valid=%b",
                         i, acc_out, valid_out, exp_acc[i], (i == 2));
            end
        end
        n_tests++;
        if (ps_out !== 2'd3 || busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got ps=%0d busy=%b, want ps=3 busy=0", ps_out, busy_out);
        end
        step(1'b0, 6'd0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (valid_out !== 1'b0 || ps_out !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_idle: got valid=%b ps=%0d, want valid=0 ps=0", valid_out, ps_out);
        end
    endtask

    task automatic test_saturation;
        step(1'b1, 6'd63, 6'd0, 1'b0, 6'd0);
        for (int i = 1; i <= 64; i++) begin
            step(1'b0, 6'd0, 6'd0, 1'b1, 6'd63);
            if (i == 16) begin
                n_tests++;
                if (acc_out !== 16'd63504 || sat_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_pre: got acc=%0d sat=%b, want acc=63504 sat=0", acc_out, sat_out);
                end
            end
            if (i == 17) begin
                n_tests++;
                if (acc_out !== 16'hFFFF || sat_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_hit: got acc=%0d sat=%b, want acc=65535 sat=1", acc_out, sat_out);
                end
            end
            if (i == 63) begin
                n_tests++;
                if (valid_out !== 1'b0 || ps_out !== 2'd2) begin
                    n_fail++;
                    $display("FAIL sat_63: got valid=%b ps=%0d, want valid=0 ps=2", valid_out, ps_out);
                end
            end
        end
        n_tests++;
        if (valid_out !== 1'b1 || acc_out !== 16'hFFFF || sat_out !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_done: got valid=%b acc=%0d sat=%b, want valid=1 acc=65535 sat=1",
                     valid_out, acc_out, sat_out);
        end
        step(1'b0, 6'd0, 6'd0, 1'b0, 6'd0);
    endtask

    task automatic test_err;
        step(1'b1, 6'd3, 6'd2, 1'b0, 6'd0);
        n_tests++;
        if (sat_out !== 1'b0 || err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL err_load_clears: got sat=%b err=%b, want 0 0", sat_out, err_out);
        end
        step(1'b0, 6'd0, 6'd0, 1'b1, 6'd1);
        step(1'b1, 6'd9, 6'd5, 1'b1, 6'd1);
        n_tests++;
        if (err_out !== 1'b1 || acc_out !== 16'd6 || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL err_accum_load: got err=%b acc=%0d valid=%b, want err=1 acc=6 valid=1",
                     err_out, acc_out, valid_out);
        end
        step(1'b0, 6'd0, 6'd0, 1'b0, 6'd0);
        n_tests++;
        if (err_out !== 1'b1 || ps_out !== 2'd0) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b ps=%0d, want err=1 ps=0", err_out, ps_out);
        end
    endtask

    task automatic test_reload;
        step(1'b1, 6'd3, 6'd2, 1'b0, 6'd0);
        step(1'b1, 6'd7, 6'd1, 1'b1, 6'd9);
        n_tests++;
        if (ps_out !== 2'd1 || acc_out !== 16'd0 || err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_wins: got ps=%0d acc=%0d err=%b, want ps=1 acc=0 err=0",
                     ps_out, acc_out, err_out);
        end
        step(1'b0, 6'd0, 6'd0, 1'b1, 6'd2);
        n_tests++;
        if (valid_out !== 1'b1 || acc_out !== 16'd14) begin
            n_fail++;
            $display("FAIL reload_result: got valid=%b acc=%0d, want valid=1 acc=14", valid_out, acc_out);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 6'd1, 6'd1, 1'b0, 6'd0);
        n_tests++;
        if (ps_out !== 2'd1 || valid_out !== 1'b0 || acc_out !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_load: got ps=%0d valid=%b acc=%0d, want ps=1 valid=0 acc=0",
                     ps_out, valid_out, acc_out);
        end
        step(1'b0, 6'd0, 6'd0, 1'b1, 6'd5);
        n_tests++;
        if (valid_out !== 1'b1 || acc_out !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_result: got valid=%b acc=%0d, want valid=1 acc=5", valid_out, acc_out);
        end
        step(1'b0, 6'd0, 6'd0, 1'b0, 6'd0);
    endtask

    task automatic test_midjob_reset;
        step(1'b1, 6'd2, 6'd4, 1'b0, 6'd0);
        step(1'b0, 6'd0, 6'd0, 1'b1, 6'd1);
        step(1'b0, 6'd0, 6'd0, 1'b1, 6'd1);
        n_tests++;
        if (acc_out !== 16'd4 || ps_out !== 2'd2) begin
            n_fail++;
            $display("FAIL midjob_pre: got acc=%0d ps=%0d, want acc=4 ps=2", acc_out, ps_out);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({acc_out, valid_out, busy_out, sat_out, err_out, ps_out} !== 22'd0) begin
            n_fail++;
            $display("FAIL midjob_reset: got acc=%0d v=%b b=%b s=%b e=%b ps=%0d, want all 0",
                     acc_out, valid_out, busy_out, sat_out, err_out, ps_out);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (valid_out !== 1'b0 || ps_out !== 2'd0) begin
            n_fail++;
            $display("FAIL midjob_no_valid: got valid=%b ps=%0d, want 0 0", valid_out, ps_out);
        end
        reset = 1'b1;
        step(1'b1, 6'd2, 6'd1, 1'b0, 6'd0);
        step(1'b0, 6'd0, 6'd0, 1'b1, 6'd3);
        n_tests++;
        if (valid_out !== 1'b1 || acc_out !== 16'd6) begin
            n_fail++;
            $display("FAIL midjob_recover: got valid=%b acc=%0d, want valid=1 acc=6", valid_out, acc_out);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        w_in      = '0;
        s_in      = '0;
        b_in      = '0;
        load_w_in = 1'b0;
        cnt_in    = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_err();
        test_reload();
        test_back_to_back();
        test_midjob_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_accum_datapath.md
# wb_accum_datapath

Consumer end of the weight/bias command stream produced by the `controller2C`-class controllers. It latches a weight on `load_w`, multiplies it by the incoming bias operand on every `cnt` strobe, and accumulates with saturation until the programmed sample count is reached. It then presents the result with a one-cycle valid pulse. It sits directly downstream of the controller and shares its clock and reset.

## Interface
- `DW`, default 6: width of `w`, `b`, `s`.
- `AW`, default 16: accumulator/result width; must be ≥ 2·DW.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: reset, asynchronous, active-low.
- `w_in`, input, DW: weight operand, unsigned; sampled only when `load_w_in`=1.
- `load_w_in`, input, 1: load strobe; latches `w_in` and `s_in`.
- `s_in`, input, DW: sample-count target, unsigned; 0 encodes 2^DW (64).
- `cnt_in`, input, 1: accumulate strobe.
- `b_in`, input, DW: bias operand, unsigned; sampled when `cnt_in` is accepted.
- `acc_out`, output, AW: accumulator value; holds the final result during DONE.
- `valid_out`, output, 1: one-cycle pulse, asserted in DONE.
- `busy_out`, output, 1: high in LOADED or ACCUM.
- `sat_out`, output, 1: sticky saturation flag for the current job.
- `err_out`, output, 1: sticky protocol-error flag.
- `ps_out`, output, 2: present state, for debug.

## Operation
- FSM states: IDLE=0, LOADED=1, ACCUM=2, DONE=3.
- **IDLE**
  - `load_w_in`=1: w_reg←`w_in`, tgt←`s_in` (0→64), acc←0, count←0, sat←0, err←0; go to LOADED.
  - `cnt_in` is ignored.
- **LOADED**
  - `load_w_in`=1: reload w_reg and tgt, clear acc/count/sat; stay in LOADED. `load_w_in` wins over a simultaneous `cnt_in`.
  - `cnt_in`=1 (no load): acc←sat(acc + w_reg·b_in), count←1. Go to DONE if tgt==1, else ACCUM.
- **ACCUM**
  - `cnt_in`=1: accumulate as above, count←count+1. Go to DONE when the new count equals tgt.
  - `cnt_in`=0: hold.
  - `load_w_in`=1: set err; the load is ignored and `cnt_in` in the same cycle is still accepted.
- **DONE**
  - `valid_out`=1; `acc_out` holds the result.
  - `load_w_in`=1: start a new job exactly as from IDLE and go to LOADED.
  - Otherwise go to IDLE.
  - `cnt_in` is ignored.
- Arithmetic
  - The product is DW×DW→2·DW unsigned, zero-extended to AW+1 bits.
  - The sum clamps to 2^AW−1; sat_out←1 on clamp and stays set until the next accepted load.
  - After saturation, further accumulates keep `acc_out` at its maximum.
- count is a DW+1-bit register, so that tgt=64 is reachable without wrap.
- `err_out` clears only on reset or an accepted load from IDLE or DONE.

## Timing
- Reset (async assert, sync deassert at the flop level):
  - state=IDLE
  - `acc_out`=0, `valid_out`=0, `busy_out`=0, `sat_out`=0, `err_out`=0, `ps_out`=0
  - w_reg=0, tgt=0, count=0
- Reset asserted mid-job aborts the job immediately. No `valid_out` is produced for that job.
- Accumulate latency: the multiply is combinational and the result is registered into acc on the same edge that accepts `cnt_in`.
- Result latency: `valid_out` rises on the edge that accepts the final `cnt_in`. A job of N samples takes 1 load cycle + N cnt cycles + 1 DONE cycle.
- `busy_out` and `ps_out` are registered state decodes; there is no combinational path from inputs to outputs.
- Back-to-back jobs: a load in DONE gives zero idle cycles between jobs.

## Structure
- Package `wb_accum_pkg`:
  - `state_t` enum (IDLE/LOADED/ACCUM/DONE, 2 bits)
  - default `DW`/`AW` localparams
  - `TGT_ZERO_MAP`=64
- Sub-module `wb_sat_mac`: combinational DW×DW multiply plus AW-bit saturating add. Outputs are next_acc and a clamp flag.
- Top level holds the FSM, w_reg, tgt, count, and the sticky flags.

## Test plan
- Load w=5, s=3; cnt with b=2, 4, 6 → acc=10, 30, 60. `valid_out` pulses once with `acc_out`=60, then the block returns to IDLE.
- Load w=63, s=0 (64 samples); cnt with b=63 every cycle → saturation at 2^16−1 on the 17th sample. `sat_out`=1; `valid_out` occurs after the 64th cnt with `acc_out`=65535.
- Load w=3, s=2; assert `load_w_in` with w=9 during ACCUM together with cnt b=1 → `err_out`=1, w_reg stays 3, and the sample is accumulated.
- In LOADED, assert `load_w_in` (w=7, s=1) and cnt simultaneously → the reload wins. The next cnt with b=2 gives `valid_out` with acc=14.
- During DONE, assert load w=1, s=1; then cnt b=5 → `valid_out` pulses again with acc=5, with no IDLE cycle between jobs.
- Assert reset low in ACCUM after 2 of 4 samples → all outputs are 0 immediately. After release, a new job runs normally.
